// File: rtl/spi_master_driver.sv
// Byte-wide SPI master, mode 0, MSB first, with start/busy/done handshake.
// Ports: clk_i/rst_i (sync active-high), start_i, data_in_bi[7:0] in;
//   busy_o, done_o, data_out_bo[7:0] out; spi_sclk_o, spi_mosi_o,
//   spi_cs_o (active-low) out; spi_miso_i in.
module spi_master_driver #(
  parameter int HALF_PERIOD = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int CS_GAP      = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_in_bi,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] data_out_bo,
  output logic       spi_sclk_o,
  output logic       spi_mosi_o,
  input  logic       spi_miso_i,
  output logic       spi_cs_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] C_HALF_M1  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] C_SETUP_M1 = 8'(CS_SETUP - 1);
  localparam logic [7:0] C_HOLD_M1  = 8'(CS_HOLD - 1);
  localparam logic [7:0] C_GAP_M1   = 8'(CS_GAP - 1);

  localparam bit C_LEGAL =
    (HALF_PERIOD >= 2) && (HALF_PERIOD <= 255) &&
    (CS_SETUP >= 2) && (CS_SETUP <= 255) &&
    (CS_HOLD >= 1) && (CS_HOLD <= 255) &&
    (CS_GAP >= 2) && (CS_GAP <= 255);

  state_t     r_state;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic [2:0] r_bit;
  logic [7:0] r_phase;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_dout;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_cs;

  logic [7:0] w_last;
  logic       w_end;

  // Last phase-counter value of the current state; IDLE ends every cycle
  // so the counter sits at zero until a transfer starts.
  always_comb begin
    w_last = 8'd0;
    case (r_state)
      S_SETUP:     w_last = C_SETUP_M1;
      S_HIGH,
      S_LOW:       w_last = C_HALF_M1;
      S_HOLD:      w_last = C_HOLD_M1;
      S_GAP:       w_last = C_GAP_M1;
      default:     w_last = 8'd0;
    endcase
  end

  assign w_end = (r_phase == w_last);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_tx    <= 8'd0;
      r_rx    <= 8'd0;
      r_bit   <= 3'd0;
      r_phase <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= 8'd0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs    <= 1'b1;
    end else begin
      r_done  <= 1'b0;
      r_phase <= w_end ? 8'd0 : r_phase + 8'd1;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_tx    <= data_in_bi;
            r_rx    <= 8'd0;
            r_bit   <= 3'd0;
            r_cs    <= 1'b0;
            r_mosi  <= data_in_bi[7];
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_end) begin
            r_sclk  <= 1'b1;
            r_state <= S_HIGH;
          end
        end
        S_HIGH: begin
          // Sample at the end of the high phase; the slave only moves
          // MISO after it has seen SCLK low.
          if (w_end) begin
            r_rx    <= {r_rx[6:0], spi_miso_i};
            r_sclk  <= 1'b0;
            r_tx    <= {r_tx[6:0], 1'b0};
            r_mosi  <= r_tx[6];
            r_state <= S_LOW;
          end
        end
        S_LOW: begin
          if (w_end) begin
            if (r_bit == 3'd7) begin
              r_state <= S_HOLD;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_sclk  <= 1'b1;
              r_state <= S_HIGH;
            end
          end
        end
        S_HOLD: begin
          if (w_end) begin
            r_cs    <= 1'b1;
            r_mosi  <= 1'b0;
            r_dout  <= r_rx;
            r_done  <= 1'b1;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_end) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign data_out_bo = r_dout;
  assign spi_sclk_o  = r_sclk;
  assign spi_mosi_o  = r_mosi;
  assign spi_cs_o    = r_cs;

  a_legal_params: assert property (@(posedge clk_i) C_LEGAL)
    else $error("spi_master_driver: illegal parameter value");

endmodule
